// File: rtl/aes_shift_rows_if.sv
// Beat bundle for the AES ShiftRows stage: handshake, state, round key and sidebands.
// The master side drives the beat; the slave side returns ready.
interface aes_shift_rows_if #(
  parameter int NB = 4,
  parameter int BW = 8
);
  logic                 valid;
  logic                 ready;
  logic                 inv;
  logic [4*NB*BW-1:0]   state;
  logic [4*NB*BW-1:0]   key;
  logic [BW-1:0]        rcon;
  logic                 empty;

  modport master (output valid, inv, state, key, rcon, empty, input ready);
  modport slave  (input valid, inv, state, key, rcon, empty, output ready);
endinterface

// File: rtl/aes_shift_rows_stage.sv
// Registered ShiftRows / InvShiftRows stage with RotWord prep of the key's last row.
// Define AES_SHIFT_ROWS_SKID_EN to add a 1-entry skid buffer that makes in_ready a pure flop.
module aes_shift_rows_stage #(
  parameter int NB = 4,
  parameter int BW = 8
) (
  input  logic            clk,
  input  logic            rst,
  aes_shift_rows_if.slave  in_if,
  aes_shift_rows_if.master out_if
);
  localparam int SW = 4*NB*BW;

  typedef struct packed {
    logic          inv;
    logic          empty;
    logic [BW-1:0] rcon;
    logic [SW-1:0] key;
    logic [SW-1:0] state;
  } beat_t;

  localparam beat_t BEAT_RST = '{inv: 1'b0, empty: 1'b1, rcon: '0, key: '0, state: '0};

  function automatic logic [SW-1:0] shift_state(input logic [SW-1:0] s, input logic inv);
    logic [SW-1:0] o;
    int src;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NB; c++) begin
        src = inv ? ((c - r + NB) % NB) : ((c + r) % NB);
        o[(r*NB+c)*BW +: BW] = s[(r*NB+src)*BW +: BW];
      end
    end
    return o;
  endfunction

  // Last key row is always rotated left by one byte, independent of direction.
  function automatic logic [SW-1:0] rot_key(input logic [SW-1:0] k);
    logic [SW-1:0] o;
    o = k;
    for (int c = 0; c < NB; c++) begin
      o[(3*NB+c)*BW +: BW] = k[(3*NB+((c+1)%NB))*BW +: BW];
    end
    return o;
  endfunction

  beat_t in_beat;
  beat_t out_q;
  logic  out_valid_q;
  logic  accept;
  logic  consume;

  always_comb begin
    in_beat       = BEAT_RST;
    in_beat.inv   = in_if.inv;
    in_beat.empty = in_if.empty;
    in_beat.rcon  = in_if.rcon;
    in_beat.key   = rot_key(in_if.key);
    in_beat.state = shift_state(in_if.state, in_if.inv);
  end

  assign accept  = in_if.valid && in_if.ready;
  assign consume = out_valid_q && out_if.ready;

`ifdef AES_SHIFT_ROWS_SKID_EN
  beat_t skid_q;
  logic  skid_full_q;

  assign in_if.ready = !rst && !skid_full_q;

  // A full skid implies a stalled, valid output; it drains before new input is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= BEAT_RST;
      skid_full_q <= 1'b0;
      skid_q      <= BEAT_RST;
    end else if (skid_full_q) begin
      if (out_if.ready) begin
        out_q       <= skid_q;
        skid_full_q <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || out_if.ready) begin
        out_q       <= in_beat;
        out_valid_q <= 1'b1;
      end else begin
        skid_q      <= in_beat;
        skid_full_q <= 1'b1;
      end
    end else if (consume) begin
      out_valid_q <= 1'b0;
    end
  end
`else
  assign in_if.ready = !rst && (!out_valid_q || out_if.ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= BEAT_RST;
    end else if (accept) begin
      out_q       <= in_beat;
      out_valid_q <= 1'b1;
    end else if (consume) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign out_if.valid = out_valid_q;
  assign out_if.inv   = out_q.inv;
  assign out_if.empty = out_q.empty;
  assign out_if.rcon  = out_q.rcon;
  assign out_if.key   = out_q.key;
  assign out_if.state = out_q.state;
endmodule
